// File: rtl/bandscope_pkg.sv
// Shared constants, state encoding and header-byte helper for the bandscope reader.
package bandscope_pkg;

  localparam int BS_SAMPLES     = 16384;
  localparam int BS_PKT_SAMPLES = 256;
  localparam int BS_NUM_PKTS    = 64;
  localparam int BS_HDR_LEN     = 4;
  localparam logic [7:0] BS_SYNC = 8'h7F;

  // Derived field widths: RAM address, sample-in-packet, packet index, header byte index.
  localparam int BS_ADDR_W = $clog2(BS_SAMPLES);
  localparam int BS_PKT_W  = $clog2(BS_PKT_SAMPLES);
  localparam int BS_IDX_W  = $clog2(BS_NUM_PKTS);
  localparam int BS_HDR_W  = $clog2(BS_HDR_LEN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_CAPT  = 3'd3,
    ST_HI    = 3'd4,
    ST_LO    = 3'd5,
    ST_END   = 3'd6
  } bs_rd_state_t;

  // Header layout: sync, sync, packet index, frame sequence.
  function automatic logic [7:0] bs_hdr_byte(input logic [BS_HDR_W-1:0] idx,
                                             input logic [BS_IDX_W-1:0] pkt,
                                             input logic [7:0]          seq);
    logic [7:0] b;
    b = BS_SYNC;
    case (idx)
      2'd2:    b = {{(8-BS_IDX_W){1'b0}}, pkt};
      2'd3:    b = seq;
      default: b = BS_SYNC;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bandscope_reader.sv
// Reads a completed bandscope RAM fill in address order and streams it to the
// host TX FIFO as 64 packets of (4-byte header + 256 big-endian 16-bit samples).
//
// TX handshake: tx_valid/tx_data come straight from registers. A byte transfers
// on a posedge where tx_valid && tx_ready. Once tx_valid is high, tx_data and
// tx_valid are held unchanged until that transfer happens; a new byte is only
// loaded into the output register when it is empty or emptying this cycle.
import bandscope_pkg::*;

module bandscope_reader (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         bs_on,
  input  logic         bs_ready,
  output logic [13:0]  rd_addr,
  input  logic [15:0]  rd_data,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic [7:0]   overrun_cnt,
  output logic [7:0]   frame_seq,
  output bs_rd_state_t dbg_state
);

  bs_rd_state_t         state_q, state_d;
  logic                 bs_q, bs_seen_q;
  logic                 pending_q, pending_d;
  logic [7:0]           overrun_q, overrun_d;
  logic [7:0]           seq_q, seq_d;
  logic [7:0]           seq_next_q, seq_next_d;
  logic [BS_ADDR_W-1:0] addr_q, addr_d;
  logic [BS_HDR_W-1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0]          sample_q, sample_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;

  logic req, req_on, slot_free, end_leave, start_frame, pkt_done, frame_done;

  // A level change on bs_ready (seen one register later) is one request.
  assign req       = bs_q ^ bs_seen_q;
  assign req_on    = req & bs_on;
  assign slot_free = ~tx_valid_q | tx_ready;
  // addr_q has already advanced past the last fetched sample when these are used.
  assign pkt_done   = (addr_q[BS_PKT_W-1:0] == '0);
  assign frame_done = (addr_q == '0);
  assign end_leave  = (state_q == ST_END) && slot_free;

  // Next-state logic: packet sequencing, output register loading, request bookkeeping.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    seq_d       = seq_q;
    seq_next_d  = seq_next_q;
    addr_d      = addr_q;
    hdr_cnt_d   = hdr_cnt_q;
    sample_d    = sample_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    start_frame = 1'b0;

    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;

    // While a frame runs, the first extra request is queued, further ones are counted.
    if (state_q != ST_IDLE && !end_leave && req_on) begin
      if (!pending_q)               pending_d = 1'b1;
      else if (overrun_q != 8'hFF)  overrun_d = overrun_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: start_frame = req_on;
      ST_HDR: begin
        if (slot_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = bs_hdr_byte(hdr_cnt_q, addr_q[BS_ADDR_W-1 -: BS_IDX_W], seq_q);
          hdr_cnt_d  = hdr_cnt_q + BS_HDR_W'(1);
          if (hdr_cnt_q == BS_HDR_W'(BS_HDR_LEN - 1)) state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        addr_d  = addr_q + BS_ADDR_W'(1);
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        sample_d = rd_data;
        state_d  = ST_HI;
      end
      ST_HI: begin
        if (slot_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = sample_q[15:8];
          state_d    = ST_LO;
        end
      end
      ST_LO: begin
        if (slot_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = sample_q[7:0];
          if (!pkt_done)                 state_d = ST_FETCH;
          else if (!frame_done && bs_on) state_d = ST_HDR;
          else                           state_d = ST_END;
        end
      end
      ST_END: begin
        // Wait for the final byte to leave so busy drops only after it.
        if (slot_free) begin
          if (bs_on && (pending_q || req)) begin
            start_frame = 1'b1;
            pending_d   = pending_q & req;
          end else begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      state_d    = ST_HDR;
      addr_d     = '0;
      hdr_cnt_d  = '0;
      seq_d      = seq_next_q;
      seq_next_d = seq_next_q + 8'd1;
    end
  end

  // State registers with synchronous active-low reset; toggle detector primed from bs_ready.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bs_q       <= bs_ready;
      bs_seen_q  <= bs_ready;
      pending_q  <= 1'b0;
      overrun_q  <= 8'd0;
      seq_q      <= 8'd0;
      seq_next_q <= 8'd0;
      addr_q     <= '0;
      hdr_cnt_q  <= '0;
      sample_q   <= 16'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bs_q       <= bs_ready;
      bs_seen_q  <= bs_q;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      seq_q      <= seq_d;
      seq_next_q <= seq_next_d;
      addr_q     <= addr_d;
      hdr_cnt_q  <= hdr_cnt_d;
      sample_q   <= sample_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign rd_addr     = addr_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = overrun_q;
  assign frame_seq   = seq_q;
  assign dbg_state   = state_q;

endmodule
